// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU core and its interrupt controller.
package cpu_pkg;

  localparam int unsigned NUM_SRC_C = 4;
  localparam int unsigned IRQ_ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Fixed priority: lowest set index wins.
  function automatic logic [IRQ_ID_W-1:0] prio_enc(input logic [NUM_SRC_C-1:0] v);
    prio_enc = '0;
    for (int unsigned i = NUM_SRC_C; i > 0; i--) begin
      if (v[i-1]) prio_enc = IRQ_ID_W'(i-1);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises one asynchronous request line and emits a one-cycle pulse
// on each rising edge of the synchronised level.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-captured pending sources, software mask, fixed
// priority and a single-outstanding request/ack/done handshake with the core.
module irq_controller
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_SRC_C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_SRC-1:0]  mask_wdata,
  input  logic                int_ack,
  input  logic                int_done,
  output logic                int_sig,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [NUM_SRC-1:0]  pending,
  output logic                busy
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .din  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign eligible = pending & ~mask_q;
  assign busy     = (state != IDLE);

  always_comb begin
    ack_clr = '0;
    if (state == REQ && int_ack) ack_clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pending <= '0;
      mask_q  <= '0;
      int_sig <= 1'b0;
      irq_id  <= '0;
    end else begin
      // A new edge on the bit being acknowledged survives the clear.
      pending <= (pending & ~ack_clr) | rise;
      if (mask_we) mask_q <= mask_wdata;
      unique case (state)
        IDLE: begin
          if (|eligible) begin
            irq_id  <= prio_enc(eligible);
            int_sig <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_sig <= 1'b0;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (int_done) state <= IDLE;
        end
        default: begin
          int_sig <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, async reset sequence and
// randomized traffic checked against a behavioural model.
module tb_irq_controller;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_ack = 1'b0;
  logic       int_done = 1'b0;
  logic       int_sig;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       busy;

  irq_controller #(
    .NUM_SRC(4),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .int_sig    (int_sig),
    .irq_id     (irq_id),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a source becomes pending when the level seen SYNC
  // edges ago is high and the one before it was low.
  logic [3:0] hq [$];
  logic [3:0] m_pend, m_mask, m_new, m_clr;
  logic       m_sig;
  logic [1:0] m_id;
  int         m_phase;  // 0 no request, 1 waiting for ack, 2 in ISR

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend = '0; m_mask = '0; m_sig = 1'b0; m_id = '0; m_phase = 0;
      hq.delete();
      for (int k = 0; k <= SYNC; k++) hq.push_back(4'b0);
    end else begin
      m_new = hq[SYNC-1] & ~hq[SYNC];
      m_clr = '0;
      if (m_phase == 0) begin
        if ((m_pend & ~m_mask) != 0) begin
          for (int k = 3; k >= 0; k--) if (m_pend[k] && !m_mask[k]) m_id = 2'(k);
          m_sig = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (int_ack) begin
          m_clr[m_id] = 1'b1;
          m_sig = 1'b0;
          m_phase = 2;
        end
      end else if (int_done) begin
        m_phase = 0;
      end
      m_pend = (m_pend & ~m_clr) | m_new;
      if (mask_we) m_mask = mask_wdata;
      hq.push_front(irq_in);
      void'(hq.pop_back());
    end
  end

  typedef struct {
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mwd;
    logic       ack;
    logic       done;
    logic       sig;
    logic [1:0] id;
    logic [3:0] pend;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                     input logic ack, input logic done, input logic sig,
                     input logic [1:0] id, input logic [3:0] pend, input logic bsy);
    vec_t v;
    v = '{irq, mwe, mwd, ack, done, sig, id, pend, bsy};
    tbl.push_back(v);
  endtask

  initial begin
    // Single request on source 2
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0000, 0);  // 1
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0100, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);
    add(4'b0000, 0, 4'h0, 1, 0,  0, 2'd2, 4'b0000, 1);  // 5
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 1);
    add(4'b0000, 0, 4'h0, 0, 1,  0, 2'd2, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);
    // Priority: sources 3 and 1 together
    add(4'b1010, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);  // 9
    add(4'b1010, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd2, 4'b1010, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  1, 2'd1, 4'b1010, 1);
    add(4'b0000, 0, 4'h0, 1, 0,  0, 2'd1, 4'b1000, 1);
    add(4'b0000, 0, 4'h0, 0, 1,  0, 2'd1, 4'b1000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  1, 2'd3, 4'b1000, 1);  // 15
    add(4'b0000, 0, 4'h0, 1, 0,  0, 2'd3, 4'b0000, 1);
    add(4'b0000, 0, 4'h0, 0, 1,  0, 2'd3, 4'b0000, 0);
    // Masking
    add(4'b0000, 1, 4'h1, 0, 0,  0, 2'd3, 4'b0000, 0);  // 18
    add(4'b0001, 0, 4'h0, 0, 0,  0, 2'd3, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd3, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd3, 4'b0001, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd3, 4'b0001, 0);
    add(4'b0000, 1, 4'h0, 0, 0,  0, 2'd3, 4'b0001, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  1, 2'd0, 4'b0001, 1);  // 24
    add(4'b0000, 0, 4'h0, 1, 0,  0, 2'd0, 4'b0000, 1);
    add(4'b0000, 0, 4'h0, 0, 1,  0, 2'd0, 4'b0000, 0);
    // Spurious handshakes in IDLE
    add(4'b0000, 0, 4'h0, 1, 0,  0, 2'd0, 4'b0000, 0);  // 27
    add(4'b0000, 0, 4'h0, 0, 1,  0, 2'd0, 4'b0000, 0);
    // Level input, then a fresh edge colliding with the ack clear
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0000, 0);  // 29
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0000, 0);
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd0, 4'b0100, 0);
    add(4'b0100, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);
    add(4'b0000, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);
    add(4'b0100, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);  // 34
    add(4'b0100, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);
    add(4'b0100, 0, 4'h0, 1, 0,  0, 2'd2, 4'b0100, 1);  // 36 set wins
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0100, 1);
    add(4'b0100, 0, 4'h0, 0, 1,  0, 2'd2, 4'b0100, 0);
    add(4'b0100, 0, 4'h0, 0, 0,  1, 2'd2, 4'b0100, 1);
    add(4'b0100, 0, 4'h0, 1, 0,  0, 2'd2, 4'b0000, 1);  // 40
    add(4'b0100, 0, 4'h0, 0, 1,  0, 2'd2, 4'b0000, 0);
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);
    add(4'b0100, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);
    add(4'b0000, 0, 4'h0, 0, 0,  0, 2'd2, 4'b0000, 0);

    #2 rstn = 1'b0;
    #1;
    check("reset int_sig", {31'b0, int_sig}, 32'd0);
    check("reset irq_id",  {30'b0, irq_id},  32'd0);
    check("reset pending", {28'b0, pending}, 32'd0);
    check("reset busy",    {31'b0, busy},    32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      irq_in = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
      int_ack = tbl[i].ack; int_done = tbl[i].done;
      @(negedge clk);
      check($sformatf("row%0d int_sig", i+1), {31'b0, int_sig}, {31'b0, tbl[i].sig});
      check($sformatf("row%0d irq_id", i+1),  {30'b0, irq_id},  {30'b0, tbl[i].id});
      check($sformatf("row%0d pending", i+1), {28'b0, pending}, {28'b0, tbl[i].pend});
      check($sformatf("row%0d busy", i+1),    {31'b0, busy},    {31'b0, tbl[i].bsy});
    end
    irq_in = '0; mask_we = 0; int_ack = 0; int_done = 0;

    // Reset while a request is outstanding
    irq_in = 4'b1010;
    @(negedge clk);
    irq_in = 4'b0000;
    repeat (3) @(negedge clk);
    check("pre-reset int_sig", {31'b0, int_sig}, 32'd1);
    check("pre-reset irq_id",  {30'b0, irq_id},  32'd1);
    check("pre-reset pending", {28'b0, pending}, 32'hA);
    #2 rstn = 1'b0;
    #1;
    check("async reset int_sig", {31'b0, int_sig}, 32'd0);
    check("async reset irq_id",  {30'b0, irq_id},  32'd0);
    check("async reset pending", {28'b0, pending}, 32'd0);
    check("async reset busy",    {31'b0, busy},    32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("post-reset quiet c%0d", c), {31'b0, int_sig}, 32'd0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom_range(0, 15));
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = 4'($urandom_range(0, 15));
      int_ack    = ($urandom_range(0, 2) == 0);
      int_done   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      check($sformatf("rnd%0d int_sig", c), {31'b0, int_sig}, {31'b0, m_sig});
      check($sformatf("rnd%0d irq_id", c),  {30'b0, irq_id},  {30'b0, m_id});
      check($sformatf("rnd%0d pending", c), {28'b0, pending}, {28'b0, m_pend});
      check($sformatf("rnd%0d busy", c),    {31'b0, busy},    {31'b0, m_phase != 0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
